ahb_sram_slave: RTL

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave_if.sv | 24 ++
 rtl/ahb_sram_slave.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between an AHB master and the SRAM bridge slave.
// The master side also drives the bus-level HREADY seen by the slave.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave bridging word transfers onto a start/io_done SRAM port.
// Each legal transfer: capture, one start pulse, wait for io_done or timeout.
module ahb_sram_slave #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 24,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    ahb_sram_slave_if.slave      bus,
    output logic                 start,
    output logic                 writemode,
    output logic [ADDR_BITS-1:0] address,
    output logic [DATA_BITS-1:0] w_data,
    input  logic [DATA_BITS-1:0] i_r_data,
    input  logic                 io_done
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          can_sample;
    logic          sample;
    logic          legal;
    logic          timeout;

    assign can_sample = (state == S_IDLE) || (state == S_DONE)
                     || (state == S_ERR2);
    assign sample  = can_sample && bus.HSEL && bus.HREADY
                  && bus.HTRANS[1];
    assign legal   = (bus.HSIZE == 3'b010)
                  && (bus.HADDR[1:0] == 2'b00)
                  && (bus.HADDR[31:ADDR_BITS+2] == '0);
    assign timeout = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state: io_done is only looked at in WAIT and beats the timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (sample) state_nx = legal ? S_CAPTURE : S_ERR1;
                else        state_nx = S_IDLE;
            end
            S_CAPTURE: state_nx = S_ISSUE;
            S_ISSUE:   state_nx = S_WAIT;
            S_WAIT: begin
                if (io_done)      state_nx = S_DONE;
                else if (timeout) state_nx = S_ERR1;
            end
            S_ERR1:    state_nx = S_ERR2;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Bus response and SRAM strobe, forced quiet while in reset
    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 2'b00;
        start         = 1'b0;
        if (!rst) begin
            unique case (state)
                S_CAPTURE, S_WAIT: bus.HREADYOUT = 1'b0;
                S_ISSUE: begin
                    bus.HREADYOUT = 1'b0;
                    start         = 1'b1;
                end
                S_ERR1: begin
                    bus.HREADYOUT = 1'b0;
                    bus.HRESP     = 2'b01;
                end
                S_ERR2:  bus.HRESP = 2'b01;
                default: ;
            endcase
        end
    end

    // Request latches, wait counter and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            writemode  <= 1'b0;
            address    <= '0;
            w_data     <= '0;
            bus.HRDATA <= '0;
            cnt        <= '0;
        end else begin
            if (sample && legal) begin
                address   <= bus.HADDR[ADDR_BITS+1:2];
                writemode <= bus.HWRITE;
            end
            if (state == S_CAPTURE && writemode)
                w_data <= bus.HWDATA[DATA_BITS-1:0];
            if (state == S_ISSUE)
                cnt <= '0;
            else if (state == S_WAIT && !io_done && !timeout)
                cnt <= cnt + CW'(1);
            if (state == S_WAIT && io_done && !writemode)
                bus.HRDATA <= 32'(i_r_data);
        end
    end

endmodule
